lsu_access_ctrl: RTL

- Initiator side of the core's LSU word port.
- Accepts one load/store request at a time from the core datapath (address, funct3, store data) and turns it into word-aligned LSU read/write cycles.
- Sub-word stores use read-modify-write. Load results are sign- or zero-extended.
- Sits between the single-cycle core's execute stage and the existing lsu memory/IO block. Misaligned and illegal accesses are rejected without touching the bus.

---
 rtl/lsu_access_pkg.sv | 39 +++
 rtl/lsu_lane_unit.sv | 48 ++++
 rtl/lsu_access_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lsu_access_pkg.sv
// Shared types and funct3 decode helpers for the LSU access controller.
package lsu_access_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Only meaningful for legal funct3; unsigned variants share the size bits.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// store merge of sub-word data into a previously read word.
module lsu_lane_unit
    import lsu_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (funct3)
            F3_B:    merge_data[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
            F3_H:    merge_data[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Initiator side of the LSU word port: one request at a time, word-aligned
// bus cycles, read-modify-write for sub-word stores.
//
// state | meaning
// IDLE  | ready for a request; captures it on accept
// READ  | one-cycle word read strobe, loads latency counter
// WAIT  | counts down read latency, samples read data at terminal count
// WRITE | one-cycle word write strobe with full or merged word
// RESP  | one-cycle response pulse back to the core
module lsu_access_ctrl
    import lsu_access_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_vld,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_lsu_we,
    output logic        o_lsu_re,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_wdata,
    input  logic [31:0] i_lsu_rdata
);

    localparam logic [1:0] CNT_LOAD = 2'(RD_LATENCY - 1);

    state_e      state;
    logic        we_q;
    logic        err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic [1:0]  cnt_q;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    // word_q holds the raw store data until the read returns, then the merged word.
    lsu_lane_unit u_lane (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .rdata      (i_lsu_rdata),
        .wdata      (word_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            cnt_q   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_vld) begin
                        we_q    <= i_req_we;
                        f3_q    <= i_req_funct3;
                        addr_q  <= i_req_addr;
                        word_q  <= i_req_wdata;
                        rdata_q <= 32'h0;
                        if (!is_legal(i_req_we, i_req_funct3) ||
                            is_misaligned(i_req_funct3, i_req_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= (i_req_we && i_req_funct3 == F3_W) ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    cnt_q <= CNT_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        if (we_q) begin
                            word_q <= merge_data;
                            state  <= WRITE;
                        end else begin
                            rdata_q <= load_data;
                            state   <= RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                WRITE: state <= RESP;
                RESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req_rdy   = (state == IDLE);
    assign o_lsu_re    = (state == READ);
    assign o_lsu_we    = (state == WRITE);
    assign o_rsp_vld   = (state == RESP);
    assign o_rsp_err   = (state == RESP) && err_q;
    assign o_rsp_rdata = (state == RESP) ? rdata_q : 32'h0;
    assign o_lsu_wdata = (state == WRITE) ? word_q : 32'h0;
    assign o_lsu_addr  = (state == READ || state == WAIT || state == WRITE) ?
                         {addr_q[31:2], 2'b00} : 32'h0;

endmodule
